imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder on the fetch-side memory port: receives address/op-enable/read-write from the fetch stage and returns one instruction word per read request.
- Word-organised single-port array with a configurable-latency registered read pipeline, a core write path, and an init/boot-load port for filling the program before or during execution.
- Out-of-range and misaligned requests return NOP_INSTR and assert an error flag.

Parameters:
- MEM_WORDS, 128, number of INSTR_SIZE-bit words in the array (power of two).
- LATENCY, 1, read latency in cycles, legal range 1..4.
- BASE_ADDR, BOOT_ADDR, byte address of word 0.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- addr  in  INSTR_SIZE  byte address from fetch (rd_pc)
- rd_wr  in  1  RD = read, any other value = write
- op_en  in  1  request valid this cycle
- wr_data  in  INSTR_SIZE  core write data
- rd_data  out  INSTR_SIZE  returned instruction (to fetch rd_instr)
- rd_valid  out  1  rd_data carries the result of a read request
- err  out  1  returned word belongs to an out-of-range or misaligned read
- init_we  in  1  init-port write enable
- init_addr  in  $clog2(MEM_WORDS)  init-port word index
- init_data  in  INSTR_SIZE  init-port write data

Behaviour:
- Decode: off = addr - BASE_ADDR (INSTR_SIZE bits, wraps); idx = off[$clog2(MEM_WORDS)+1:2].
  - in_range = (addr >= BASE_ADDR) and (off >> 2) < MEM_WORDS.
  - misaligned = addr[1:0] != 0.
- Read request = op_en & (rd_wr == RD), sampled at rising edge N.
  - Result lands in rd_data/rd_valid/err at edge N+LATENCY-1 and is visible during cycle N+LATENCY-1..N+LATENCY.
  - LATENCY=1: rd_data updates on the same edge that samples the request, so fetch sees it in the following cycle.
  - Good request: rd_data = array[idx], err = 0. Out-of-range or misaligned: rd_data = NOP_INSTR, err = 1, no array access.
  - Fully pipelined: one request accepted per cycle, no stalls, no backpressure.
- Bubble (op_en = 0 or write) enters the pipeline with valid = 0.
  - When a bubble reaches the output: rd_valid = 0, err = 0, rd_data holds its previous value.
- Write = op_en & (rd_wr != RD) & in_range & ~misaligned: array[idx] <= wr_data at the edge.
  - Illegal write is dropped silently; it enters a bubble and does not assert err.
- Init write: init_we => array[init_addr] <= init_data at the edge, independent of op_en.
  - Same edge, same index as a core write: init wins.
  - Init and core write to different indices: both performed.
- Read-after-write:
  - Write at edge N, read of the same word sampled at edge N+1 returns the new data.
  - Read and init write to the same word at the same edge return the old data (read-before-write).
- Reset (asynchronous, active-high), applied immediately:
  - All pipeline stages invalid; rd_data = NOP_INSTR, rd_valid = 0, err = 0.
  - Array contents are not cleared.
  - In-flight reads are discarded; no stale result emerges after reset release.
- First request is accepted on the first rising edge with reset low.
- Address wrap: addr < BASE_ADDR (off wraps) is out of range, never aliased onto valid words.

Test Plan:
- Init-load words 0..3 with 0x00000013, 0x00100093, 0x00200113, 0x00300193; LATENCY=1; sequential reads at BASE_ADDR+0,4,8,12 with op_en=1 -> rd_data returns the four words on consecutive cycles, rd_valid=1, err=0.
- LATENCY=3, back-to-back reads of idx 0 and 1 -> first result 2 cycles after the LATENCY=1 timing, then one per cycle, no gaps.
- Write 0xDEADBEEF to BASE_ADDR+8 at edge N, read the same address at N+1 -> 0xDEADBEEF; same-edge init and core write to idx 2 (init 0x11111111) -> a subsequent read returns 0x11111111.
- Read BASE_ADDR+2, BASE_ADDR-4, BASE_ADDR+4*MEM_WORDS -> each returns NOP_INSTR with err=1, rd_valid=1; array unchanged.
- op_en=0 for 2 cycles between reads -> rd_valid=0 for exactly 2 output cycles, rd_data holds the last word, err=0.
- LATENCY=4, issue 3 reads, assert reset for 1 cycle mid-flight -> outputs go to NOP_INSTR/0/0 immediately, no stale valid afterwards, array contents preserved on a re-read.

Source files
------------

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for the fetch-side memory port. It holds a
// word-organised program array and answers one read per cycle through a
// registered pipeline of LATENCY stages. Reads outside the mapped window, or
// reads that are not word aligned, return NOP_INSTR and raise err. The core
// may also write the array through the same port. A separate init port
// fills the program before or during execution.
//
// Parameters:
//   INSTR_SIZE : instruction / address width in bits
//   MEM_WORDS  : number of INSTR_SIZE-bit words (power of two)
//   LATENCY    : read latency in cycles, legal range 1..4
//   BOOT_ADDR  : default load address of the program image
//   BASE_ADDR  : byte address of word 0 (word aligned)
//   NOP_INSTR  : word returned for illegal reads and after reset
//   RD         : rd_wr value that selects a read
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   asynchronous active-high reset of the read pipeline
//   addr       in   byte address from fetch
//   rd_wr      in   RD = read, any other value = write
//   op_en      in   request valid this cycle
//   wr_data    in   core write data
//   rd_data    out  returned instruction word
//   rd_valid   out  rd_data carries the result of a read request
//   err        out  returned word belongs to an out-of-range or misaligned read
//   init_we    in   init-port write enable
//   init_addr  in   init-port word index
//   init_data  in   init-port write data
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int                    INSTR_SIZE = 32,
    parameter int                    MEM_WORDS  = 128,
    parameter int                    LATENCY    = 1,
    parameter logic [INSTR_SIZE-1:0] BOOT_ADDR  = 32'h0000_1000,
    parameter logic [INSTR_SIZE-1:0] BASE_ADDR  = BOOT_ADDR,
    parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h0000_0013,
    parameter logic                  RD         = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INSTR_SIZE-1:0]        addr,
    input  logic                         rd_wr,
    input  logic                         op_en,
    input  logic [INSTR_SIZE-1:0]        wr_data,
    output logic [INSTR_SIZE-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         err,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [INSTR_SIZE-1:0]        init_data
);

    localparam int AW     = $clog2(MEM_WORDS);
    localparam int STAGES = LATENCY;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    // BASE_ADDR is word aligned, so the word offset is the difference of the
    // upper address bits. The subtraction wraps for addr < BASE_ADDR; the
    // explicit compare below keeps such addresses from aliasing onto the
    // array.
    logic [INSTR_SIZE-3:0] off_word;
    logic [AW-1:0]         idx;
    logic                  in_range;
    logic                  misaligned;
    logic                  legal;
    logic                  rd_req;
    logic                  core_we;

    assign off_word   = addr[INSTR_SIZE-1:2] - BASE_ADDR[INSTR_SIZE-1:2];
    assign idx        = off_word[AW-1:0];
    assign in_range   = (addr >= BASE_ADDR) && (off_word[INSTR_SIZE-3:AW] == '0);
    assign misaligned = (addr[1:0] != 2'b00);
    assign legal      = in_range && !misaligned;
    assign rd_req     = op_en && (rd_wr == RD);
    // Illegal core writes are dropped; they simply become a pipeline bubble.
    assign core_we    = op_en && (rd_wr != RD) && legal;

    // -----------------------------------------------------------------------
    // Program array (never reset; contents survive a pipeline reset)
    // -----------------------------------------------------------------------
    logic [INSTR_SIZE-1:0] mem_q [0:MEM_WORDS-1];

    // The init write is issued last so it wins over a core write to the same
    // word on the same edge.
    always_ff @(posedge clk) begin
        if (core_we) begin
            mem_q[idx] <= wr_data;
        end
        if (init_we) begin
            mem_q[init_addr] <= init_data;
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline: stage 0 samples the array on the request edge (the array
    // is read before this edge's writes land, giving read-before-write for a
    // coincident init write). Stage STAGES-1 is the output register.
    // -----------------------------------------------------------------------
    logic [STAGES-1:0]     vld_q;
    logic [STAGES-1:0]     vld_d;
    logic [STAGES-1:0]     err_q;
    logic [STAGES-1:0]     err_d;
    logic [INSTR_SIZE-1:0] data_q [0:STAGES-1];
    logic [INSTR_SIZE-1:0] data_d [0:STAGES-1];

    always_comb begin
        vld_d[0]  = rd_req;
        err_d[0]  = rd_req && !legal;
        data_d[0] = legal ? mem_q[idx] : NOP_INSTR;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k]  = vld_q[k-1];
            err_d[k]  = err_q[k-1];
            data_d[k] = data_q[k-1];
        end
        // A bubble arriving at the output leaves the last returned word in
        // place so fetch keeps seeing a stable value.
        if (!vld_d[STAGES-1]) begin
            data_d[STAGES-1] = data_q[STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= NOP_INSTR;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign rd_data  = data_q[STAGES-1];
    assign rd_valid = vld_q[STAGES-1];
    assign err      = err_q[STAGES-1];

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam int          MW   = 128;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic        RDV  = 1'b1;
    localparam int          HIST = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rd_wr;
    logic        op_en;
    logic [31:0] wr_data;
    logic        init_we;
    logic [6:0]  init_addr;
    logic [31:0] init_data;

    logic [31:0] rd_data1, rd_data3, rd_data4;
    logic        rd_valid1, rd_valid3, rd_valid4;
    logic        err1, err3, err4;

    always #5 clk = ~clk;

    imem_responder #(.MEM_WORDS(MW), .LATENCY(1), .BASE_ADDR(BASE)) u_l1 (
        .clk(clk), .reset(reset), .addr(addr), .rd_wr(rd_wr), .op_en(op_en),
        .wr_data(wr_data), .rd_data(rd_data1), .rd_valid(rd_valid1), .err(err1),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

    imem_responder #(.MEM_WORDS(MW), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (
        .clk(clk), .reset(reset), .addr(addr), .rd_wr(rd_wr), .op_en(op_en),
        .wr_data(wr_data), .rd_data(rd_data3), .rd_valid(rd_valid3), .err(err3),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

    imem_responder #(.MEM_WORDS(MW), .LATENCY(4), .BASE_ADDR(BASE)) u_l4 (
        .clk(clk), .reset(reset), .addr(addr), .rd_wr(rd_wr), .op_en(op_en),
        .wr_data(wr_data), .rd_data(rd_data4), .rd_valid(rd_valid4), .err(err4),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

    // Reference model: program memory plus a per-edge history of read results.
    logic [31:0] mem_m   [0:MW-1];
    logic        rec_vld [0:HIST-1];
    logic [31:0] rec_data[0:HIST-1];
    logic        rec_err [0:HIST-1];
    logic [31:0] last_d  [0:2];
    int          n        = 0;
    int          last_rst = -1;
    int          compared   = 0;
    int          mismatched = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    // Returns the word index of a legal byte address, or -1 if illegal.
    function automatic int word_of(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        if (off < 0 || off >= 4 * MW || (off % 4) != 0) return -1;
        return int'(off / 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " L1 rd_data"},  rd_data1, NOP);
        chk({tag, " L1 rd_valid"}, {31'd0, rd_valid1}, 32'd0);
        chk({tag, " L1 err"},      {31'd0, err1}, 32'd0);
        chk({tag, " L3 rd_data"},  rd_data3, NOP);
        chk({tag, " L3 rd_valid"}, {31'd0, rd_valid3}, 32'd0);
        chk({tag, " L3 err"},      {31'd0, err3}, 32'd0);
        chk({tag, " L4 rd_data"},  rd_data4, NOP);
        chk({tag, " L4 rd_valid"}, {31'd0, rd_valid4}, 32'd0);
        chk({tag, " L4 err"},      {31'd0, err4}, 32'd0);
    endtask

    // After edge e, a latency-L responder shows the request sampled at edge e-L+1.
    task automatic check_edge(input int e);
        for (int k = 0; k < 3; k++) begin
            int          src;
            logic        v;
            logic        ee;
            logic [31:0] od;
            logic        ov;
            logic        oe;
            src = e - lat_of(k) + 1;
            v   = (src >= 0) && (src > last_rst) && rec_vld[src];
            ee  = v && rec_err[src];
            if (v) last_d[k] = rec_data[src];
            case (k)
                0:       begin od = rd_data1; ov = rd_valid1; oe = err1; end
                1:       begin od = rd_data3; ov = rd_valid3; oe = err3; end
                default: begin od = rd_data4; ov = rd_valid4; oe = err4; end
            endcase
            chk($sformatf("L%0d edge%0d rd_valid", lat_of(k), e), {31'd0, ov}, {31'd0, v});
            chk($sformatf("L%0d edge%0d err", lat_of(k), e), {31'd0, oe}, {31'd0, ee});
            chk($sformatf("L%0d edge%0d rd_data", lat_of(k), e), od, last_d[k]);
        end
    endtask

    // Advance one clock edge with the currently driven inputs.
    task automatic step();
        int w;
        if (n >= HIST) begin
            mismatched++;
            $display("FAIL history overflow observed=%0d required<%0d", n, HIST);
            $fatal(1, "history overflow");
        end
        rec_vld[n]  = !reset && op_en && (rd_wr == RDV);
        rec_data[n] = 32'd0;
        rec_err[n]  = 1'b0;
        w = word_of(addr);
        if (rec_vld[n]) begin
            rec_data[n] = (w < 0) ? NOP : mem_m[w];
            rec_err[n]  = (w < 0);
        end
        if (reset) begin
            last_rst = n;
            for (int k = 0; k < 3; k++) last_d[k] = NOP;
        end else begin
            if (op_en && rd_wr != RDV && w >= 0) mem_m[w] = wr_data;
            if (init_we) mem_m[init_addr] = init_data;
        end
        @(posedge clk);
        #1;
        check_edge(n);
        n++;
    endtask

    task automatic drive(input logic oe, input logic rw, input logic [31:0] a,
                         input logic [31:0] wd, input logic iwe,
                         input logic [6:0] ia, input logic [31:0] id);
        op_en = oe; rd_wr = rw; addr = a; wr_data = wd;
        init_we = iwe; init_addr = ia; init_data = id;
        step();
    endtask

    task automatic rd(input logic [31:0] a);
        drive(1'b1, RDV, a, 32'd0, 1'b0, 7'd0, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, ~RDV, a, d, 1'b0, 7'd0, 32'd0);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, RDV, 32'd0, 32'd0, 1'b0, 7'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] boot [0:3];
        boot[0] = 32'h0000_0013; boot[1] = 32'h0010_0093;
        boot[2] = 32'h0020_0113; boot[3] = 32'h0030_0193;
        for (int k = 0; k < 3; k++) last_d[k] = NOP;

        // Power-on reset: outputs forced immediately and held.
        reset = 1'b1; op_en = 1'b0; rd_wr = RDV; addr = '0; wr_data = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        #1;
        chk_reset("por");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por_hold");
        reset = 1'b0;

        // Boot-load the whole array through the init port.
        for (int i = 0; i < MW; i++)
            drive(1'b0, RDV, 32'd0, 32'd0, 1'b1, 7'(i), (i < 4) ? boot[i] : $urandom);

        // Sequential fetch of the boot words, back to back.
        rd(BASE + 0); rd(BASE + 4); rd(BASE + 8); rd(BASE + 12);
        idle(4);

        // Back-to-back reads of idx 0 and 1.
        rd(BASE); rd(BASE + 4);
        idle(4);

        // Core write followed immediately by a read of the same word.
        wr(BASE + 8, 32'hDEAD_BEEF);
        rd(BASE + 8);
        // Init and core write to idx 2 on the same edge: init wins.
        drive(1'b1, ~RDV, BASE + 8, 32'h2222_2222, 1'b1, 7'd2, 32'h1111_1111);
        rd(BASE + 8);
        // Init and core write to different words on the same edge.
        drive(1'b1, ~RDV, BASE + 20, 32'h5555_5555, 1'b1, 7'd6, 32'h6666_6666);
        rd(BASE + 20); rd(BASE + 24);
        idle(4);

        // Out-of-range and misaligned reads.
        rd(BASE + 2); rd(BASE - 4); rd(BASE + 4 * MW); rd(32'hFFFF_FFFC);
        // Illegal writes are dropped; re-read the words they could hit.
        wr(BASE - 4, 32'hBAD0_0001); wr(BASE + 1, 32'hBAD0_0002);
        wr(BASE + 4 * MW, 32'hBAD0_0003);
        rd(BASE); rd(BASE + 4 * MW - 4);
        idle(4);

        // Gap of two idle cycles between reads.
        rd(BASE + 12); idle(2); rd(BASE + 16);
        idle(4);

        // Read and init write to the same word on one edge: old data returned.
        drive(1'b1, RDV, BASE + 40, 32'd0, 1'b1, 7'd10, 32'hCAFE_F00D);
        rd(BASE + 40);
        idle(4);

        // Reset mid-flight with three reads outstanding.
        rd(BASE + 4); rd(BASE + 8); rd(BASE + 12);
        reset = 1'b1;
        #1;
        chk_reset("midreset");
        idle(1);
        reset = 1'b0;
        idle(4);
        rd(BASE + 4); rd(BASE + 8); rd(BASE + 12);
        idle(4);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        oe;
            logic        rw;
            logic [31:0] a;
            logic        iwe;
            int          sel;
            oe  = ($urandom_range(0, 3) != 0);
            rw  = ($urandom_range(0, 3) != 0) ? RDV : ~RDV;
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 4 * $urandom_range(0, MW - 1);
            else if (sel == 7) a = BASE + $urandom_range(0, 4 * MW - 1);
            else if (sel == 8) a = BASE - 4 * $urandom_range(1, 8);
            else               a = BASE + 4 * MW + 4 * $urandom_range(0, 8);
            iwe = ($urandom_range(0, 7) == 0);
            drive(oe, rw, a, $urandom, iwe, 7'($urandom_range(0, MW - 1)), $urandom);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
